ship_placer: RTL and testbench
==============================

# ship_placer

Places one ship on the battleship grid by checking and then writing the grid cell-status memory. It validates bounds, reads every target cell and confirms each one is free, then commits the requested status code to all cells in one atomic sequence. It is the writer of the cell-status store that GridEngine reads. The game controller and the AI drive it with one request per ship, using the configured ship sizes.

## Interface
Parameters:
- GRID_W, 10, grid columns
- GRID_H, 10, grid rows
- ADDR_W, 7, cell address width; must satisfy 2^ADDR_W ≥ GRID_W·GRID_H
- STATUS_W, 4, cell status code width

Ports:
- Clocking and reset:
  - clk_in  in  1  system clock; single clock domain
  - rst_n_in  in  1  asynchronous, active-low reset
- Request channel:
  - req_valid  in  1  placement request present
  - req_ready  out  1  block idle and accepting
  - req_x  in  4  column of the bow cell
  - req_y  in  4  row of the bow cell
  - req_vertical  in  1  0 = ship extends toward +x; 1 = ship extends toward +y
  - req_size  in  4  ship length in cells
  - req_status  in  STATUS_W  code written to each cell (e.g. player_occ = 1, ia_occ = 2)
  - cell_status_free  in  STATUS_W  code meaning "free" (quasi-static, normally 0)
- Memory port:
  - mem_addr  out  ADDR_W  cell address, y·GRID_W + x
  - mem_rd_data  in  STATUS_W  synchronous read data, 1-cycle latency
  - mem_we  out  1  write strobe
  - mem_wr_data  out  STATUS_W  write data
- Result:
  - done  out  1  one-cycle pulse at end of each request
  - result_code  out  2  0 = OK, 1 = out of bounds, 2 = collision, 3 = bad size

## Operation
- FSM states: IDLE, VALIDATE, CHECK, WRITE, DONE.
- IDLE:
  - req_ready = 1.
  - When req_valid is high, latch x, y, vertical, size, and status, then go to VALIDATE.
- VALIDATE (1 cycle), checks in priority order:
  - size = 0 or size > max(GRID_W, GRID_H) → code 3.
  - Otherwise, x ≥ GRID_W or y ≥ GRID_H → code 1.
  - Otherwise, end coordinate (x+size for horizontal, y+size for vertical) > grid dimension → code 1.
  - Compute the end coordinate with at least 5 bits so it cannot wrap.
  - Any error → DONE. No error → CHECK.
- CHECK (pipelined read):
  - Issue addresses for k = 0..size-1 on consecutive cycles.
  - Compare mem_rd_data against cell_status_free one cycle after each address.
  - The state lasts size+1 cycles.
  - On the first mismatch, stop issuing reads, set code 2, and go to DONE. No write is ever issued in this case.
  - All cells free → WRITE.
- WRITE:
  - size cycles with mem_we = 1, mem_wr_data = latched status, and mem_addr stepping over cells k = 0..size-1.
  - Address step is +1 for horizontal, +GRID_W for vertical.
- DONE (1 cycle):
  - done = 1 and result_code is updated; result_code then holds until the next DONE.
  - Return to IDLE.
- Address arithmetic:
  - Registered incremental add, no multiplier in the loop.
  - Base address y·GRID_W + x is formed in VALIDATE.
- A req_valid asserted while busy is ignored; req_ready is 0 in every state except IDLE.
- Request fields are sampled only on acceptance. Later changes have no effect.

## Timing
- Acceptance edge = E0. VALIDATE occupies cycle 1.
- Error detected in VALIDATE: done in cycle 2.
- Success:
  - CHECK occupies cycles 2..size+2.
  - WRITE occupies cycles size+3..2·size+2.
  - done in cycle 2·size+3.
  - req_ready returns in cycle 2·size+4.
- Collision at cell k: done two cycles after address k was issued.
- Reset values:
  - req_ready = 1, done = 0, result_code = 0.
  - mem_we = 0, mem_addr = 0, mem_wr_data = 0.
  - FSM in IDLE.
- Reset asserted mid-operation:
  - mem_we drops immediately (asynchronously).
  - Cells already written stay written; the controller owns cleanup.
- mem_we is never 1 outside WRITE.
- A back-to-back request is accepted in the IDLE cycle right after DONE.

## Test plan
- Empty grid; request x=2, y=3, horizontal, size=4, status=1.
  - Writes to addresses 32, 33, 34, 35, each with data 1.
  - done in cycle 11 with code 0.
- Empty grid; request x=9, y=6, vertical, size=4.
  - Writes to addresses 69, 79, 89, 99.
  - Code 0.
- Request x=7, y=0, horizontal, size=4.
  - Code 1, done in cycle 2, no reads or writes.
- Request with size=0 → code 3.
- Request with size=11 → code 3.
- Preload address 45 with 2; request x=3, y=4, horizontal, size=3.
  - Reads 43, 44, 45.
  - Code 2, zero mem_we cycles.
- Assert rst_n_in low during the second WRITE cycle of a size-4 placement.
  - mem_we = 0 within the same cycle.
  - req_ready = 1 after release.
  - A following request completes with code 0.

Source files
------------

// File: rtl/ship_placer.sv
`default_nettype none
// ship_placer: validates, collision-checks and atomically writes one ship
// into the grid cell-status memory.  Rev 1.0
module ship_placer #(
  parameter int GRID_W   = 10,
  parameter int GRID_H   = 10,
  parameter int ADDR_W   = 7,
  parameter int STATUS_W = 4
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_x,
  input  logic [3:0]          req_y,
  input  logic                req_vertical,
  input  logic [3:0]          req_size,
  input  logic [STATUS_W-1:0] req_status,
  input  logic [STATUS_W-1:0] cell_status_free,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [STATUS_W-1:0] mem_rd_data,
  output logic                mem_we,
  output logic [STATUS_W-1:0] mem_wr_data,
  output logic                done,
  output logic [1:0]          result_code
);

  localparam logic [4:0]        C_GW5   = 5'(GRID_W);
  localparam logic [4:0]        C_GH5   = 5'(GRID_H);
  localparam logic [4:0]        C_MAXD5 = (GRID_W > GRID_H) ? 5'(GRID_W) : 5'(GRID_H);
  localparam logic [ADDR_W-1:0] C_GW_A  = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] C_ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, VALIDATE, CHECK, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          x_q, x_d, y_q, y_d, size_q, size_d;
  logic                vert_q, vert_d, rd_pend_q, rd_pend_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic [4:0]          k_q, k_d;
  logic [1:0]          result_code_q, result_code_d;

  logic [4:0]          w_end, w_dim, w_size5;
  logic [1:0]          w_vcode;
  logic [ADDR_W-1:0]   w_step, w_base;

  // End coordinate is formed in 5 bits so x+size cannot wrap.
  always_comb begin
    w_size5 = {1'b0, size_q};
    w_end   = vert_q ? ({1'b0, y_q} + w_size5) : ({1'b0, x_q} + w_size5);
    w_dim   = vert_q ? C_GH5 : C_GW5;
    w_step  = vert_q ? C_GW_A : C_ONE_A;
    w_base  = ADDR_W'(y_q) * C_GW_A + ADDR_W'(x_q);
    w_vcode = 2'd0;
    if (size_q == 4'd0 || w_size5 > C_MAXD5) begin
      w_vcode = 2'd3;
    end else if ({1'b0, x_q} >= C_GW5 || {1'b0, y_q} >= C_GH5) begin
      w_vcode = 2'd1;
    end else if (w_end > w_dim) begin
      w_vcode = 2'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    vert_d        = vert_q;
    size_d        = size_q;
    status_d      = status_q;
    base_d        = base_q;
    addr_d        = addr_q;
    k_d           = k_q;
    rd_pend_d     = rd_pend_q;
    result_code_d = result_code_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          x_d      = req_x;
          y_d      = req_y;
          vert_d   = req_vertical;
          size_d   = req_size;
          status_d = req_status;
          state_d  = VALIDATE;
        end
      end
      VALIDATE: begin
        base_d    = w_base;
        addr_d    = w_base;
        k_d       = 5'd0;
        rd_pend_d = 1'b0;
        if (w_vcode != 2'd0) begin
          result_code_d = w_vcode;
          state_d       = DONE;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Read data lags its address by one cycle; rd_pend_q marks it valid.
        if (rd_pend_q && mem_rd_data != cell_status_free) begin
          result_code_d = 2'd2;
          rd_pend_d     = 1'b0;
          state_d       = DONE;
        end else if (k_q < w_size5) begin
          addr_d    = addr_q + w_step;
          k_d       = k_q + 5'd1;
          rd_pend_d = 1'b1;
        end else begin
          addr_d    = base_q;
          k_d       = 5'd0;
          rd_pend_d = 1'b0;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + w_step;
        k_d    = k_q + 5'd1;
        if (k_q == w_size5 - 5'd1) begin
          result_code_d = 2'd0;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      vert_q        <= 1'b0;
      size_q        <= '0;
      status_q      <= '0;
      base_q        <= '0;
      addr_q        <= '0;
      k_q           <= '0;
      rd_pend_q     <= 1'b0;
      result_code_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      vert_q        <= vert_d;
      size_q        <= size_d;
      status_q      <= status_d;
      base_q        <= base_d;
      addr_q        <= addr_d;
      k_q           <= k_d;
      rd_pend_q     <= rd_pend_d;
      result_code_q <= result_code_d;
    end
  end

  // Strobes decode straight from the state flop so reset kills mem_we at once.
  assign req_ready   = (state_q == IDLE);
  assign done        = (state_q == DONE);
  assign mem_we      = (state_q == WRITE);
  assign mem_wr_data = (state_q == WRITE) ? status_q : '0;
  assign mem_addr    = addr_q;
  assign result_code = result_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ship_placer.sv
`default_nettype none
// tb_ship_placer: table-driven vectors plus hand sequences for ship_placer.
module tb_ship_placer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_x = '0, req_y = '0, req_size = '0, req_status = '0;
  logic       req_vertical = 1'b0;
  logic [3:0] cell_free = 4'd0;
  logic [6:0] mem_addr;
  logic [3:0] mem_rd_data;
  logic       mem_we;
  logic [3:0] mem_wr_data;
  logic       done;
  logic [1:0] result_code;

  ship_placer #(.GRID_W(10), .GRID_H(10), .ADDR_W(7), .STATUS_W(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_vertical(req_vertical),
    .req_size(req_size), .req_status(req_status),
    .cell_status_free(cell_free),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_we(mem_we), .mem_wr_data(mem_wr_data),
    .done(done), .result_code(result_code)
  );

  always #5 clk = ~clk;

  // Memory model with write log; the bench steers it through flags only.
  logic [3:0] mem [128];
  logic       clr = 1'b0, pre_we = 1'b0;
  logic [6:0] pre_addr = '0;
  logic [3:0] pre_data = '0;
  int         wr_n;
  logic [6:0] wr_addr_log [64];
  logic [3:0] wr_data_log [64];

  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= 4'd0;
      wr_n <= 0;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wr_data;
      if (wr_n < 64) begin
        wr_addr_log[wr_n] <= mem_addr;
        wr_data_log[wr_n] <= mem_wr_data;
      end
      wr_n <= wr_n + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] x, y;
    logic       vert;
    logic [3:0] size, status;
    logic       pre_en;
    int         pre_addr;
    logic [1:0] code;
    int         lat;
    int         base;
    int         step;
  } vec_t;

  vec_t       vecs [11];
  int         n_done;
  logic [6:0] addr_seen [64];
  logic       we_seen [64];

  task automatic clear_mem();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic preload(input int a, input logic [3:0] d);
    pre_we = 1'b1; pre_addr = 7'(a); pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge after done.
  task automatic do_req(input logic [3:0] x, input logic [3:0] y, input logic v,
                        input logic [3:0] s, input logic [3:0] st, input string nm);
    chk({nm, "_ready_idle"}, int'(req_ready), 1);
    req_x = x; req_y = y; req_vertical = v; req_size = s; req_status = st;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_x = ~x; req_y = ~y; req_vertical = ~v; req_size = ~s; req_status = ~st;
    chk({nm, "_ready_busy"}, int'(req_ready), 0);
    n_done = 1;
    for (int i = 0; i < 64; i++) begin
      addr_seen[i] = '0;
      we_seen[i]   = 1'b0;
    end
    while (1) begin
      addr_seen[n_done] = mem_addr;
      we_seen[n_done]   = mem_we;
      if (done || n_done >= 60) break;
      @(negedge clk);
      n_done++;
    end
    @(negedge clk);
    chk({nm, "_ready_after"}, int'(req_ready), 1);
    chk({nm, "_done_pulse"}, int'(done), 0);
  endtask

  task automatic check_vec(input vec_t v, input string nm);
    int nwr, bad_seq, bad_we, lo, hi;
    nwr = (v.code == 2'd0) ? int'(v.size) : 0;
    chk({nm, "_code"}, int'(result_code), int'(v.code));
    chk({nm, "_latency"}, n_done, v.lat);
    chk({nm, "_nwrites"}, wr_n, nwr);
    bad_seq = 0;
    for (int i = 0; i < nwr && i < 64; i++)
      if (wr_addr_log[i] !== 7'(v.base + i * v.step) || wr_data_log[i] !== v.status)
        bad_seq++;
    chk({nm, "_write_seq_errs"}, bad_seq, 0);
    lo = int'(v.size) + 3;
    hi = 2 * int'(v.size) + 2;
    bad_we = 0;
    for (int c = 1; c <= n_done && c < 64; c++)
      if (we_seen[c] !== ((nwr != 0) && c >= lo && c <= hi)) bad_we++;
    chk({nm, "_we_window_errs"}, bad_we, 0);
  endtask

  initial begin
    //            x     y     v     size  stat  pre   paddr code  lat base step
    vecs[0]  = '{4'd2, 4'd3, 1'b0, 4'd4,  4'd1, 1'b0, 0,  2'd0, 11, 32, 1};
    vecs[1]  = '{4'd9, 4'd6, 1'b1, 4'd4,  4'd2, 1'b0, 0,  2'd0, 11, 69, 10};
    vecs[2]  = '{4'd7, 4'd0, 1'b0, 4'd4,  4'd1, 1'b0, 0,  2'd1, 2,  0,  1};
    vecs[3]  = '{4'd0, 4'd0, 1'b0, 4'd0,  4'd1, 1'b0, 0,  2'd3, 2,  0,  1};
    vecs[4]  = '{4'd0, 4'd0, 1'b0, 4'd11, 4'd1, 1'b0, 0,  2'd3, 2,  0,  1};
    vecs[5]  = '{4'd0, 4'd0, 1'b0, 4'd10, 4'd3, 1'b0, 0,  2'd0, 23, 0,  1};
    vecs[6]  = '{4'd0, 4'd9, 1'b1, 4'd2,  4'd1, 1'b0, 0,  2'd1, 2,  0,  10};
    vecs[7]  = '{4'd10,4'd0, 1'b0, 4'd1,  4'd1, 1'b0, 0,  2'd1, 2,  0,  1};
    vecs[8]  = '{4'd12,4'd0, 1'b0, 4'd15, 4'd1, 1'b0, 0,  2'd3, 2,  0,  1};
    vecs[9]  = '{4'd0, 4'd0, 1'b1, 4'd10, 4'd2, 1'b0, 0,  2'd0, 23, 0,  10};
    vecs[10] = '{4'd0, 4'd0, 1'b1, 4'd3,  4'd1, 1'b1, 0,  2'd2, 4,  0,  10};

    #2;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_code", int'(result_code), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wdata", int'(mem_wr_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_mem();

    for (int i = 0; i < 11; i++) begin
      clear_mem();
      if (vecs[i].pre_en) preload(vecs[i].pre_addr, 4'd1);
      do_req(vecs[i].x, vecs[i].y, vecs[i].vert, vecs[i].size, vecs[i].status,
             $sformatf("vec%0d", i));
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Collision at k=2 with read-address trace.
    clear_mem();
    preload(45, 4'd2);
    do_req(4'd3, 4'd4, 1'b0, 4'd3, 4'd1, "coll");
    chk("coll_rd0", int'(addr_seen[2]), 43);
    chk("coll_rd1", int'(addr_seen[3]), 44);
    chk("coll_rd2", int'(addr_seen[4]), 45);
    chk("coll_code", int'(result_code), 2);
    chk("coll_latency", n_done, 6);
    chk("coll_nwrites", wr_n, 0);

    // Back-to-back: second request enters in the IDLE cycle right after DONE.
    clear_mem();
    do_req(4'd2, 4'd3, 1'b0, 4'd4, 4'd1, "b2b_a");
    do_req(4'd0, 4'd5, 1'b1, 4'd3, 4'd2, "b2b_b");
    chk("b2b_code", int'(result_code), 0);
    chk("b2b_latency", n_done, 9);
    chk("b2b_nwrites", wr_n, 7);
    chk("b2b_wr4", int'(wr_addr_log[4]), 50);
    chk("b2b_wr6", int'(wr_addr_log[6]), 70);
    chk("b2b_data6", int'(wr_data_log[6]), 2);

    // Reset during the second WRITE cycle of a size-4 placement.
    clear_mem();
    req_x = 4'd2; req_y = 4'd3; req_vertical = 1'b0; req_size = 4'd4; req_status = 4'd1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c < 8; c++) @(negedge clk);
    chk("rstw_we_before", int'(mem_we), 1);
    chk("rstw_addr_before", int'(mem_addr), 33);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_async", int'(mem_we), 0);
    chk("rstw_ready", int'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_cell32", int'(mem[32]), 1);
    chk("rstw_cell33", int'(mem[33]), 0);
    chk("rstw_code_rst", int'(result_code), 0);
    do_req(4'd0, 4'd0, 1'b0, 4'd2, 4'd1, "rstw_next");
    chk("rstw_next_code", int'(result_code), 0);
    chk("rstw_next_latency", n_done, 7);
    chk("rstw_next_cell1", int'(mem[1]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
